kronos_lsu: RTL and testbench
=============================

// Module: kronos_lsu
// PURPOSE
//   Load/store unit downstream of the execute stage. Accepts one memory op per
//   valid/ready handshake and drives the core's data bus (data_*). Returns
//   aligned, sign/zero-extended load data to register writeback.
//   Flags misaligned accesses instead of issuing them to the bus.
// PARAMETERS
//   ALIGN_CHECK  1  1: misaligned half/word ops flagged and dropped; 0: low addr bits used as offset, no check
// PORTS
//   clk              in   1   core clock
//   rstz             in   1   asynchronous reset, active-low
//   lsu_vld          in   1   request valid from EX
//   lsu_rdy          out  1   LSU can accept a request
//   lsu_addr         in   32  byte address (effective address from EX ALU)
//   lsu_wdata        in   32  store data (rs2), LSB-justified
//   lsu_size         in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   lsu_unsigned     in   1   1: zero-extend load (LBU/LHU)
//   lsu_store        in   1   1: store, 0: load
//   lsu_rd           in   5   load destination register
//   data_addr        out  32  word-aligned bus address
//   data_rd_data     in   32  bus read data, valid with data_ack
//   data_wr_data     out  32  bus write data, lane-replicated
//   data_mask        out  4   byte enables
//   data_wr_en       out  1   1: write cycle
//   data_req         out  1   bus request, held until data_ack
//   data_ack         in   1   bus completion
//   regwr_data       out  32  load writeback data
//   regwr_sel        out  5   load writeback register
//   regwr_en         out  1   writeback strobe, one cycle
//   misaligned       out  1   one-cycle misaligned-access flag
//   misaligned_addr  out  32  offending address, held until next flag
// BEHAVIOUR
//   - States: IDLE, BUSY, WB. lsu_rdy = (state==IDLE).
//   - Reset (rstz low, async): state IDLE; all registered outputs 0
//     (data_addr, data_wr_data, data_mask, data_wr_en, data_req, regwr_*,
//     misaligned, misaligned_addr); lsu_rdy=1. Reset mid-transaction aborts
//     it: data_req drops immediately, no writeback, ack ignored thereafter.
//   - Accept on lsu_vld & lsu_rdy (cycle N). Offset off=lsu_addr[1:0].
//   - Misaligned (ALIGN_CHECK=1): half with off[0]=1, word with off!=0.
//     -> misaligned=1 in N+1, misaligned_addr=lsu_addr, no bus op, stay IDLE.
//   - Otherwise registered at N+1: data_addr={addr[31:2],2'b00};
//     mask: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111;
//     wr_data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata;
//     data_wr_en=lsu_store; data_req=1; state BUSY. Offset, size, unsigned,
//     rd latched internally.
//   - BUSY: all data_* outputs held stable until data_ack sampled high.
//     On ack edge: data_req, data_wr_en, data_mask -> 0; load -> WB; store -> IDLE.
//     data_ack while data_req low is ignored.
//   - Load extract from data_rd_data (captured at ack): byte lane
//     rd_data[8*off +: 8], half lane rd_data[16*off[1] +: 16]; sign-extend
//     unless lsu_unsigned; word passes through.
//   - WB (one cycle): regwr_en=1, regwr_sel=rd, regwr_data=result; if rd==0
//     regwr_en stays 0. Next cycle IDLE, regwr_en=0 (regwr_data/sel hold).
//   - Latency: ack at cycle M (M>=N+1) -> regwr_en at M+1; lsu_rdy at M+2
//     (load) or M+1 (store). Zero-wait ack (M=N+1) is legal.
//   - One outstanding transaction; no new request accepted outside IDLE.
// TESTING
//   - LB addr 0x103, rd=5, rd_data 0x80112233, ack 1 cycle -> data_addr 0x100,
//     mask 4'b1000, regwr_data 0xFFFFFF80, regwr_sel 5; LBU -> 0x00000080.
//   - SH addr 0x102 wdata 0x1234ABCD -> data_addr 0x100, mask 4'b1100,
//     wr_data 0xABCDABCD, wr_en 1; no regwr_en; lsu_rdy back the cycle after ack.
//   - LW addr 0x101 -> misaligned=1 one cycle, misaligned_addr 0x101,
//     data_req never asserts, lsu_rdy stays 1.
//   - LW addr 0x200 with ack delayed 3 cycles -> data_* stable, lsu_rdy=0
//     throughout, regwr_data=rd_data the cycle after ack.
//   - LH addr 0x002 rd=0 -> bus transaction completes, regwr_en never asserts.
//   - Assert rstz low while BUSY, then ack -> data_req low at once, no
//     writeback, lsu_rdy=1 after reset release.

Source files
------------

// File: rtl/kronos_lsu_if.sv
// Bundles the EX-side request channel, the core data bus, the writeback port and
// the misaligned flag. The LSU is the bus master; the surrounding core is the slave side.
interface kronos_lsu_if;
    logic        lsu_vld;
    logic        lsu_rdy;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic        lsu_store;
    logic [4:0]  lsu_rd;

    logic [31:0] data_addr;
    logic [31:0] data_rd_data;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;

    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;

    logic        misaligned;
    logic [31:0] misaligned_addr;

    modport master (
        input  lsu_vld, lsu_addr, lsu_wdata, lsu_size, lsu_unsigned, lsu_store, lsu_rd,
        input  data_rd_data, data_ack,
        output lsu_rdy,
        output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
        output regwr_data, regwr_sel, regwr_en,
        output misaligned, misaligned_addr
    );

    modport slave (
        output lsu_vld, lsu_addr, lsu_wdata, lsu_size, lsu_unsigned, lsu_store, lsu_rd,
        output data_rd_data, data_ack,
        input  lsu_rdy,
        input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
        input  regwr_data, regwr_sel, regwr_en,
        input  misaligned, misaligned_addr
    );
endinterface

// File: rtl/kronos_lsu.sv
// Load/store unit: one outstanding data-bus transaction, lane-aligned stores,
// sign/zero-extended loads and a misaligned-access flag instead of a bus op.
module kronos_lsu #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input logic          clk,
    input logic          rstz,
    kronos_lsu_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_store;
    logic [4:0]  r_rd;

    logic [31:0] r_data_addr;
    logic [31:0] r_data_wr_data;
    logic [3:0]  r_data_mask;
    logic        r_data_wr_en;
    logic        r_data_req;
    logic [31:0] r_regwr_data;
    logic [4:0]  r_regwr_sel;
    logic        r_regwr_en;
    logic        r_misaligned;
    logic [31:0] r_misaligned_addr;

    logic [1:0]  w_off;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_accept;
    logic        w_misal;
    logic        w_ack;
    logic        w_rdy;
    logic [3:0]  w_mask;
    logic [31:0] w_wr_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_off     = bus.lsu_addr[1:0];
    assign w_is_half = (bus.lsu_size == 2'b01);
    // Size 2'b11 is reserved and handled exactly like a word access.
    assign w_is_word = bus.lsu_size[1];
    assign w_accept  = bus.lsu_vld && w_rdy;
    assign w_misal   = ALIGN_CHECK && ((w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00)));
    assign w_ack     = (r_state == BUSY) && r_data_req && bus.data_ack;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept && !w_misal) w_next = BUSY;
            BUSY: if (w_ack) w_next = r_store ? IDLE : WB;
            WB:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rdy     = (r_state == IDLE);
        w_mask    = 4'b1111;
        w_wr_data = bus.lsu_wdata;
        if (!w_is_word) begin
            if (w_is_half) begin
                w_mask    = 4'b0011 << w_off;
                w_wr_data = {2{bus.lsu_wdata[15:0]}};
            end else begin
                w_mask    = 4'b0001 << w_off;
                w_wr_data = {4{bus.lsu_wdata[7:0]}};
            end
        end
        w_byte      = bus.data_rd_data[{r_off, 3'b000} +: 8];
        w_half      = bus.data_rd_data[{r_off[1], 4'b0000} +: 16];
        w_load_data = bus.data_rd_data;
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = bus.data_rd_data;
        endcase
    end

    // Strobes (misaligned, regwr_en) default low so each lasts exactly one cycle.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_off             <= 2'b00;
            r_size            <= 2'b00;
            r_unsigned        <= 1'b0;
            r_store           <= 1'b0;
            r_rd              <= 5'd0;
            r_data_addr       <= 32'd0;
            r_data_wr_data    <= 32'd0;
            r_data_mask       <= 4'd0;
            r_data_wr_en      <= 1'b0;
            r_data_req        <= 1'b0;
            r_regwr_data      <= 32'd0;
            r_regwr_sel       <= 5'd0;
            r_regwr_en        <= 1'b0;
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= 32'd0;
        end else begin
            r_misaligned <= 1'b0;
            r_regwr_en   <= 1'b0;
            if (w_accept) begin
                if (w_misal) begin
                    r_misaligned      <= 1'b1;
                    r_misaligned_addr <= bus.lsu_addr;
                end else begin
                    r_data_addr    <= {bus.lsu_addr[31:2], 2'b00};
                    r_data_mask    <= w_mask;
                    r_data_wr_data <= w_wr_data;
                    r_data_wr_en   <= bus.lsu_store;
                    r_data_req     <= 1'b1;
                    r_off          <= w_off;
                    r_size         <= bus.lsu_size;
                    r_unsigned     <= bus.lsu_unsigned;
                    r_store        <= bus.lsu_store;
                    r_rd           <= bus.lsu_rd;
                end
            end
            if (w_ack) begin
                r_data_req   <= 1'b0;
                r_data_wr_en <= 1'b0;
                r_data_mask  <= 4'd0;
                if (!r_store) begin
                    r_regwr_data <= w_load_data;
                    r_regwr_sel  <= r_rd;
                    r_regwr_en   <= (r_rd != 5'd0);
                end
            end
        end
    end

    assign bus.lsu_rdy         = w_rdy;
    assign bus.data_addr       = r_data_addr;
    assign bus.data_wr_data    = r_data_wr_data;
    assign bus.data_mask       = r_data_mask;
    assign bus.data_wr_en      = r_data_wr_en;
    assign bus.data_req        = r_data_req;
    assign bus.regwr_data      = r_regwr_data;
    assign bus.regwr_sel       = r_regwr_sel;
    assign bus.regwr_en        = r_regwr_en;
    assign bus.misaligned      = r_misaligned;
    assign bus.misaligned_addr = r_misaligned_addr;

endmodule

// File: tb/tb_kronos_lsu.sv
// Directed bench for kronos_lsu: hand-computed loads, stores, misaligned
// accesses, wait states, rd==0 suppression and reset during a bus transaction.
module tb_kronos_lsu;

    logic clk;
    logic rstz;
    int   checkCount;
    int   passCount;

    kronos_lsu_if bus ();

    kronos_lsu #(.ALIGN_CHECK(1'b1)) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one request for a single cycle; returns in the cycle after acceptance.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                                 input logic uns, input logic store, input logic [4:0] rd);
        bus.lsu_addr     = addr;
        bus.lsu_wdata    = wdata;
        bus.lsu_size     = size;
        bus.lsu_unsigned = uns;
        bus.lsu_store    = store;
        bus.lsu_rd       = rd;
        bus.lsu_vld      = 1'b1;
        tick();
        bus.lsu_vld      = 1'b0;
    endtask

    task automatic ackBus(input logic [31:0] rdData);
        bus.data_ack     = 1'b1;
        bus.data_rd_data = rdData;
        tick();
        bus.data_ack     = 1'b0;
        bus.data_rd_data = 32'hDEAD_BEEF;
    endtask

    // Full load with zero-wait ack: checks the bus request and the writeback cycle.
    task automatic loadCase(input string tag, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                            input logic [4:0] rd, input logic [31:0] rdData,
                            input logic [31:0] expAddr, input logic [3:0] expMask, input logic [31:0] expData);
        applyStimulus(addr, 32'h0, size, uns, 1'b0, rd);
        checkOutput({tag, "_addr"}, bus.data_addr, expAddr);
        checkOutput({tag, "_mask"}, {28'd0, bus.data_mask}, {28'd0, expMask});
        checkOutput({tag, "_req"}, {31'd0, bus.data_req}, 32'd1);
        ackBus(rdData);
        checkOutput({tag, "_wben"}, {31'd0, bus.regwr_en}, 32'd1);
        checkOutput({tag, "_wbdata"}, bus.regwr_data, expData);
        checkOutput({tag, "_wbsel"}, {27'd0, bus.regwr_sel}, {27'd0, rd});
        checkOutput({tag, "_rdyWb"}, {31'd0, bus.lsu_rdy}, 32'd0);
        tick();
        checkOutput({tag, "_wbenOff"}, {31'd0, bus.regwr_en}, 32'd0);
        checkOutput({tag, "_rdyBack"}, {31'd0, bus.lsu_rdy}, 32'd1);
        checkOutput({tag, "_wbhold"}, bus.regwr_data, expData);
    endtask

    initial begin
        checkCount       = 0;
        passCount        = 0;
        rstz             = 1'b0;
        bus.lsu_vld      = 1'b0;
        bus.lsu_addr     = 32'd0;
        bus.lsu_wdata    = 32'd0;
        bus.lsu_size     = 2'b00;
        bus.lsu_unsigned = 1'b0;
        bus.lsu_store    = 1'b0;
        bus.lsu_rd       = 5'd0;
        bus.data_ack     = 1'b0;
        bus.data_rd_data = 32'd0;
        tick();
        tick();
        checkOutput("rst_req", {31'd0, bus.data_req}, 32'd0);
        checkOutput("rst_addr", bus.data_addr, 32'd0);
        checkOutput("rst_mask", {28'd0, bus.data_mask}, 32'd0);
        checkOutput("rst_wrdata", bus.data_wr_data, 32'd0);
        checkOutput("rst_wben", {31'd0, bus.regwr_en}, 32'd0);
        checkOutput("rst_misal", {31'd0, bus.misaligned}, 32'd0);
        checkOutput("rst_rdy", {31'd0, bus.lsu_rdy}, 32'd1);
        rstz = 1'b1;
        tick();

        loadCase("lb103",  32'h103, 2'b00, 1'b0, 5'd5, 32'h8011_2233, 32'h100, 4'b1000, 32'hFFFF_FF80);
        loadCase("lbu103", 32'h103, 2'b00, 1'b1, 5'd5, 32'h8011_2233, 32'h100, 4'b1000, 32'h0000_0080);
        loadCase("lb101",  32'h101, 2'b00, 1'b0, 5'd6, 32'h0000_7F00, 32'h100, 4'b0010, 32'h0000_007F);
        loadCase("lh000",  32'h000, 2'b01, 1'b0, 5'd4, 32'h1234_F00F, 32'h000, 4'b0011, 32'hFFFF_F00F);
        loadCase("lhu002", 32'h002, 2'b01, 1'b1, 5'd3, 32'h8001_1234, 32'h000, 4'b1100, 32'h0000_8001);

        // SH 0x102: lanes 2-3, halfword replicated, ready again right after ack.
        applyStimulus(32'h102, 32'h1234_ABCD, 2'b01, 1'b0, 1'b1, 5'd0);
        checkOutput("sh_addr", bus.data_addr, 32'h100);
        checkOutput("sh_mask", {28'd0, bus.data_mask}, 32'h0000_000C);
        checkOutput("sh_wrdata", bus.data_wr_data, 32'hABCD_ABCD);
        checkOutput("sh_wren", {31'd0, bus.data_wr_en}, 32'd1);
        checkOutput("sh_rdyBusy", {31'd0, bus.lsu_rdy}, 32'd0);
        ackBus(32'h0);
        checkOutput("sh_wben", {31'd0, bus.regwr_en}, 32'd0);
        checkOutput("sh_rdy", {31'd0, bus.lsu_rdy}, 32'd1);
        checkOutput("sh_reqOff", {31'd0, bus.data_req}, 32'd0);
        checkOutput("sh_wrenOff", {31'd0, bus.data_wr_en}, 32'd0);
        checkOutput("sh_maskOff", {28'd0, bus.data_mask}, 32'd0);

        applyStimulus(32'h105, 32'h0000_00A5, 2'b00, 1'b0, 1'b1, 5'd0);
        checkOutput("sb_addr", bus.data_addr, 32'h104);
        checkOutput("sb_mask", {28'd0, bus.data_mask}, 32'h0000_0002);
        checkOutput("sb_wrdata", bus.data_wr_data, 32'hA5A5_A5A5);
        ackBus(32'h0);

        // LW 0x101 is flagged, never reaches the bus.
        applyStimulus(32'h101, 32'h0, 2'b10, 1'b0, 1'b0, 5'd2);
        checkOutput("lwmis_flag", {31'd0, bus.misaligned}, 32'd1);
        checkOutput("lwmis_addr", bus.misaligned_addr, 32'h101);
        checkOutput("lwmis_req", {31'd0, bus.data_req}, 32'd0);
        checkOutput("lwmis_rdy", {31'd0, bus.lsu_rdy}, 32'd1);
        tick();
        checkOutput("lwmis_flagOff", {31'd0, bus.misaligned}, 32'd0);
        checkOutput("lwmis_addrHold", bus.misaligned_addr, 32'h101);
        checkOutput("lwmis_req2", {31'd0, bus.data_req}, 32'd0);

        applyStimulus(32'h103, 32'h0, 2'b01, 1'b0, 1'b0, 5'd2);
        checkOutput("lhmis_flag", {31'd0, bus.misaligned}, 32'd1);
        checkOutput("lhmis_addr", bus.misaligned_addr, 32'h103);
        checkOutput("lhmis_req", {31'd0, bus.data_req}, 32'd0);
        tick();

        // LW 0x200 with three wait states: bus held stable and ready low.
        applyStimulus(32'h200, 32'h0, 2'b10, 1'b0, 1'b0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("lwwait_addr%0d", i), bus.data_addr, 32'h200);
            checkOutput($sformatf("lwwait_mask%0d", i), {28'd0, bus.data_mask}, 32'h0000_000F);
            checkOutput($sformatf("lwwait_req%0d", i), {31'd0, bus.data_req}, 32'd1);
            checkOutput($sformatf("lwwait_rdy%0d", i), {31'd0, bus.lsu_rdy}, 32'd0);
            tick();
        end
        ackBus(32'hCAFE_F00D);
        checkOutput("lwwait_wben", {31'd0, bus.regwr_en}, 32'd1);
        checkOutput("lwwait_wbdata", bus.regwr_data, 32'hCAFE_F00D);
        checkOutput("lwwait_wbsel", {27'd0, bus.regwr_sel}, 32'd7);
        tick();

        // LH to x0: bus op completes, no writeback strobe.
        applyStimulus(32'h002, 32'h0, 2'b01, 1'b0, 1'b0, 5'd0);
        checkOutput("lhx0_req", {31'd0, bus.data_req}, 32'd1);
        ackBus(32'h8001_1234);
        checkOutput("lhx0_wben", {31'd0, bus.regwr_en}, 32'd0);
        checkOutput("lhx0_reqOff", {31'd0, bus.data_req}, 32'd0);
        tick();
        checkOutput("lhx0_wben2", {31'd0, bus.regwr_en}, 32'd0);
        checkOutput("lhx0_rdy", {31'd0, bus.lsu_rdy}, 32'd1);

        // Stray ack while idle must not create a writeback.
        ackBus(32'h1111_1111);
        checkOutput("idleack_wben", {31'd0, bus.regwr_en}, 32'd0);
        checkOutput("idleack_rdy", {31'd0, bus.lsu_rdy}, 32'd1);

        // Reset while BUSY aborts the transaction; a late ack is ignored.
        applyStimulus(32'h300, 32'h0, 2'b10, 1'b0, 1'b0, 5'd9);
        checkOutput("rstbusy_req", {31'd0, bus.data_req}, 32'd1);
        rstz = 1'b0;
        #1;
        checkOutput("rstbusy_reqDrop", {31'd0, bus.data_req}, 32'd0);
        bus.data_ack     = 1'b1;
        bus.data_rd_data = 32'h5555_AAAA;
        tick();
        rstz = 1'b1;
        tick();
        bus.data_ack = 1'b0;
        checkOutput("rstbusy_wben", {31'd0, bus.regwr_en}, 32'd0);
        checkOutput("rstbusy_rdy", {31'd0, bus.lsu_rdy}, 32'd1);
        checkOutput("rstbusy_req2", {31'd0, bus.data_req}, 32'd0);
        checkOutput("rstbusy_wbdata", bus.regwr_data, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
